usart_command_handler: RTL and testbench

USART_COMMAND_HANDLER -- requirements
Module: usart_command_handler

---
 rtl/usart_cmd_pkg.sv | 22 ++
 rtl/usart_command_handler_if.sv | 28 ++
 rtl/usart_reg_bank.sv | 49 ++++
 rtl/usart_command_handler.sv | 117 +++++++++++
 tb/tb_usart_command_handler.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usart_cmd_pkg.sv
// Shared command/status encodings, device ID and FSM state type
// for the USART command handler and its register bank.
package usart_cmd_pkg;

  localparam logic [4:0] CMD_WRITE = 5'h01;
  localparam logic [4:0] CMD_READ  = 5'h02;
  localparam logic [4:0] CMD_PING  = 5'h03;

  localparam logic [2:0] ST_OK       = 3'b000;
  localparam logic [2:0] ST_BAD_CMD  = 3'b001;
  localparam logic [2:0] ST_BAD_ADDR = 3'b010;
  localparam logic [2:0] ST_RO       = 3'b011;

  localparam logic [31:0] ID_VALUE = 32'h5DAC_0001;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    SEND
  } state_t;

endpackage

// File: rtl/usart_command_handler_if.sv
// Packet/response handshake between the USART manager (master) and the
// command handler (slave).
interface usart_cmd_if #(
  parameter int MSG_LENGTH    = 48,
  parameter int DATA_LENGTH   = 32,
  parameter int ADDRWIDTH     = 8,
  parameter int COMMAND_WIDTH = 5
);

  logic                     packet_received;
  logic [COMMAND_WIDTH-1:0] command;
  logic [ADDRWIDTH-1:0]     reg_addr;
  logic [DATA_LENGTH-1:0]   rx_data;
  logic                     send_data;
  logic [MSG_LENGTH-1:0]    tx_data;
  logic                     data_sent;

  modport master (
    output packet_received, command, reg_addr, rx_data, data_sent,
    input  send_data, tx_data
  );

  modport slave (
    input  packet_received, command, reg_addr, rx_data, data_sent,
    output send_data, tx_data
  );

endinterface

// File: rtl/usart_reg_bank.sv
// Register bank: entry 0 is the constant device ID, entries 1..NUM_REGS-1
// are writable flops with a combinational read port and flattened view.
module usart_reg_bank
  import usart_cmd_pkg::*;
#(
  parameter int DATA_LENGTH = 32,
  parameter int NUM_REGS    = 16,
  parameter int IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wr_en,
  input  logic [IDX_W-1:0]                wr_idx,
  input  logic [DATA_LENGTH-1:0]          wr_data,
  input  logic [IDX_W-1:0]                rd_idx,
  output logic [DATA_LENGTH-1:0]          rd_data,
  output logic [NUM_REGS*DATA_LENGTH-1:0] reg_bank
);

  logic [DATA_LENGTH-1:0] regs [NUM_REGS-1:1];

  // Entry 0 has no storage, so writes aimed at index 0 simply match nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr_en && wr_idx == IDX_W'(i)) begin
          regs[i] <= wr_data;
        end
      end
    end
  end

  always_comb begin
    rd_data  = DATA_LENGTH'(ID_VALUE);
    reg_bank = '0;
    reg_bank[DATA_LENGTH-1:0] = DATA_LENGTH'(ID_VALUE);
    for (int i = 1; i < NUM_REGS; i++) begin
      reg_bank[i*DATA_LENGTH +: DATA_LENGTH] = regs[i];
      if (rd_idx == IDX_W'(i)) begin
        rd_data = regs[i];
      end
    end
  end

endmodule

// File: rtl/usart_command_handler.sv
// Decodes USART packets (write/read/ping) against a register bank and
// holds a response message until the manager reports it transmitted.
module usart_command_handler
  import usart_cmd_pkg::*;
#(
  parameter int MSG_LENGTH    = 48,
  parameter int DATA_LENGTH   = 32,
  parameter int ADDRWIDTH     = 8,
  parameter int COMMAND_WIDTH = 5,
  parameter int NUM_REGS      = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  usart_cmd_if.slave                      bus,
  output logic [NUM_REGS*DATA_LENGTH-1:0] reg_bank,
  output logic                            reg_wr_strobe,
  output logic                            busy,
  output logic [7:0]                      drop_count
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_t                   state;
  logic [COMMAND_WIDTH-1:0] cmd_q;
  logic [ADDRWIDTH-1:0]     addr_q;
  logic [DATA_LENGTH-1:0]   data_q;
  logic [DATA_LENGTH-1:0]   rd_data;
  logic [DATA_LENGTH-1:0]   resp_data;
  logic [2:0]               status;
  logic                     wr_en;
  logic                     addr_ok;

  usart_reg_bank #(
    .DATA_LENGTH(DATA_LENGTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_idx  (addr_q[IDX_W-1:0]),
    .wr_data (data_q),
    .rd_idx  (addr_q[IDX_W-1:0]),
    .rd_data (rd_data),
    .reg_bank(reg_bank)
  );

  assign busy    = (state != IDLE);
  assign addr_ok = (32'(addr_q) < NUM_REGS);

  // Decode of the latched packet; only acted on while in EXEC.
  always_comb begin
    status    = ST_OK;
    resp_data = '0;
    wr_en     = 1'b0;
    case (cmd_q)
      CMD_WRITE: begin
        if (!addr_ok) begin
          status = ST_BAD_ADDR;
        end else if (addr_q == '0) begin
          status = ST_RO;
        end else begin
          resp_data = data_q;
          wr_en     = (state == EXEC);
        end
      end
      CMD_READ: begin
        if (!addr_ok) status = ST_BAD_ADDR;
        else          resp_data = rd_data;
      end
      CMD_PING: resp_data = data_q;
      default:  status = ST_BAD_CMD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cmd_q         <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      bus.send_data <= 1'b0;
      bus.tx_data   <= '0;
      reg_wr_strobe <= 1'b0;
      drop_count    <= 8'd0;
    end else begin
      reg_wr_strobe <= 1'b0;
      if (bus.packet_received && state != IDLE && drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
      case (state)
        IDLE: begin
          if (bus.packet_received) begin
            cmd_q  <= bus.command;
            addr_q <= bus.reg_addr;
            data_q <= bus.rx_data;
            state  <= EXEC;
          end
        end
        EXEC: begin
          bus.tx_data   <= MSG_LENGTH'({cmd_q, status, addr_q, resp_data});
          bus.send_data <= 1'b1;
          reg_wr_strobe <= wr_en;
          state         <= SEND;
        end
        SEND: begin
          if (bus.data_sent) begin
            bus.send_data <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usart_command_handler.sv
// Self-checking bench for usart_command_handler: directed scenarios plus
// randomized transactions against a behavioural register/response model.
module tb_usart_command_handler;
  import usart_cmd_pkg::*;

  localparam int NREGS = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREGS*32-1:0]  reg_bank;
  logic                 reg_wr_strobe;
  logic                 busy;
  logic [7:0]           drop_count;

  usart_cmd_if bus ();

  usart_command_handler dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .reg_bank     (reg_bank),
    .reg_wr_strobe(reg_wr_strobe),
    .busy         (busy),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int strobe_count = 0;
  logic [31:0] model_regs [NREGS];
  int model_drop;

  always @(posedge clk) begin
    if (reg_wr_strobe === 1'b1) strobe_count <= strobe_count + 1;
  end

  task automatic idle_inputs();
    bus.packet_received = 1'b0;
    bus.command         = '0;
    bus.reg_addr        = '0;
    bus.rx_data         = '0;
    bus.data_sent       = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) model_regs[i] = 32'h0;
    model_regs[0] = ID_VALUE;
    model_drop = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  function automatic logic [NREGS*32-1:0] model_flat();
    logic [NREGS*32-1:0] f;
    for (int i = 0; i < NREGS; i++) f[i*32 +: 32] = model_regs[i];
    return f;
  endfunction

  task automatic model_drop_one();
    if (model_drop < 255) model_drop++;
  endtask

  // Response expected from the command rules; updates model registers.
  task automatic model_apply(input logic [4:0] cmd, input logic [7:0] addr,
                             input logic [31:0] data,
                             output logic [47:0] resp, output bit wrote);
    logic [2:0]  st;
    logic [31:0] d;
    st = ST_OK;
    d = 32'h0;
    wrote = 1'b0;
    if (cmd == CMD_PING) begin
      d = data;
    end else if (cmd == CMD_READ || cmd == CMD_WRITE) begin
      if (int'(addr) >= NREGS) st = ST_BAD_ADDR;
      else if (cmd == CMD_READ) d = model_regs[addr];
      else if (addr == 8'h00) st = ST_RO;
      else begin
        model_regs[addr] = data;
        d = data;
        wrote = 1'b1;
      end
    end else begin
      st = ST_BAD_CMD;
    end
    resp = {cmd, st, addr, d};
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the EXEC cycle.
  task automatic issue_packet(input logic [4:0] cmd, input logic [7:0] addr,
                              input logic [31:0] data);
    bus.packet_received = 1'b1;
    bus.command         = cmd;
    bus.reg_addr        = addr;
    bus.rx_data         = data;
    @(negedge clk);
    bus.packet_received = 1'b0;
  endtask

  task automatic release_response();
    bus.data_sent = 1'b1;
    @(negedge clk);
    bus.data_sent = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    bus.packet_received = 1'b1;
    bus.command = CMD_WRITE;
    bus.reg_addr = 8'h02;
    bus.rx_data = 32'h1234_5678;
    repeat (3) @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    total++; if (bus.send_data !== 1'b0) begin bad++; $display("[TB] FAIL rst_send: got %b want 0", bus.send_data); end
    total++; if (bus.tx_data !== 48'h0) begin bad++; $display("[TB] FAIL rst_tx: got %h want 0", bus.tx_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
    total++; if (drop_count !== 8'd0) begin bad++; $display("[TB] FAIL rst_drop: got %0d want 0", drop_count); end
    total++; if (reg_wr_strobe !== 1'b0) begin bad++; $display("[TB] FAIL rst_strobe: got %b want 0", reg_wr_strobe); end
    total++; if (reg_bank !== model_flat()) begin bad++; $display("[TB] FAIL rst_regs: got %h want %h", reg_bank, model_flat()); end
  endtask

  task automatic test_write_read();
    logic [47:0] resp;
    bit wrote;
    int s0;
    s0 = strobe_count;
    model_apply(CMD_WRITE, 8'h03, 32'hDEADBEEF, resp, wrote);
    issue_packet(CMD_WRITE, 8'h03, 32'hDEADBEEF);
    total++; if (bus.send_data !== 1'b0 || busy !== 1'b1) begin bad++; $display("[TB] FAIL wr_n1: got send=%b busy=%b want send=0 busy=1", bus.send_data, busy); end
    @(negedge clk);
    total++; if (bus.send_data !== 1'b1) begin bad++; $display("[TB] FAIL wr_n2_send: got %b want 1", bus.send_data); end
    total++; if (bus.tx_data !== 48'h08_03_DEADBEEF) begin bad++; $display("[TB] FAIL wr_tx: got %h want %h", bus.tx_data, 48'h08_03_DEADBEEF); end
    total++; if (reg_wr_strobe !== 1'b1 || reg_bank[3*32 +: 32] !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL wr_visible: got strobe=%b reg3=%h want 1/deadbeef", reg_wr_strobe, reg_bank[3*32 +: 32]); end
    release_response();
    total++; if (busy !== 1'b0 || bus.send_data !== 1'b0) begin bad++; $display("[TB] FAIL wr_done: got busy=%b send=%b want 0/0", busy, bus.send_data); end
    total++; if (strobe_count - s0 !== 1) begin bad++; $display("[TB] FAIL wr_strobes: got %0d want 1", strobe_count - s0); end

    model_apply(CMD_READ, 8'h03, 32'h0, resp, wrote);
    issue_packet(CMD_READ, 8'h03, 32'h0);
    @(negedge clk);
    total++; if (bus.tx_data !== 48'h10_03_DEADBEEF) begin bad++; $display("[TB] FAIL rd3_tx: got %h want %h", bus.tx_data, 48'h10_03_DEADBEEF); end
    release_response();
    issue_packet(CMD_READ, 8'h00, 32'hFFFF_FFFF);
    @(negedge clk);
    total++; if (bus.tx_data !== 48'h10_00_5DAC0001) begin bad++; $display("[TB] FAIL rd0_tx: got %h want %h", bus.tx_data, 48'h10_00_5DAC0001); end
    release_response();
  endtask

  task automatic test_errors();
    logic [4:0]  cmds  [4] = '{CMD_WRITE, CMD_WRITE, 5'h1F, CMD_PING};
    logic [7:0]  addrs [4] = '{8'h00, 8'h10, 8'h03, 8'hFF};
    logic [31:0] datas [4] = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'hCAFE_F00D};
    logic [47:0] wants [4] = '{48'h0B_00_00000000, 48'h0A_10_00000000,
                               48'hF9_03_00000000, 48'h18_FF_CAFEF00D};
    logic [47:0] resp;
    bit wrote;
    int s0;
    s0 = strobe_count;
    for (int i = 0; i < 4; i++) begin
      model_apply(cmds[i], addrs[i], datas[i], resp, wrote);
      issue_packet(cmds[i], addrs[i], datas[i]);
      @(negedge clk);
      total++; if (bus.tx_data !== wants[i]) begin bad++; $display("[TB] FAIL err_tx%0d: got %h want %h", i, bus.tx_data, wants[i]); end
      release_response();
    end
    total++; if (strobe_count - s0 !== 0) begin bad++; $display("[TB] FAIL err_strobes: got %0d want 0", strobe_count - s0); end
    total++; if (reg_bank[31:0] !== ID_VALUE || reg_bank !== model_flat()) begin bad++; $display("[TB] FAIL err_regs: got %h want %h", reg_bank, model_flat()); end
  endtask

  task automatic test_stray_data_sent();
    logic [47:0] resp;
    bit wrote;
    release_response();
    total++; if (busy !== 1'b0 || bus.send_data !== 1'b0) begin bad++; $display("[TB] FAIL stray_idle: got busy=%b send=%b want 0/0", busy, bus.send_data); end
    model_apply(CMD_PING, 8'h44, 32'h0BAD_CAFE, resp, wrote);
    issue_packet(CMD_PING, 8'h44, 32'h0BAD_CAFE);
    bus.data_sent = 1'b1;
    @(negedge clk);
    bus.data_sent = 1'b0;
    @(negedge clk);
    total++; if (bus.send_data !== 1'b1 || bus.tx_data !== resp) begin bad++; $display("[TB] FAIL stray_exec: got send=%b tx=%h want 1/%h", bus.send_data, bus.tx_data, resp); end
    release_response();
  endtask

  task automatic test_random();
    logic [4:0]  cmd;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [47:0] resp;
    bit wrote;
    int s0, r, k;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4) cmd = CMD_WRITE;
      else if (r < 7) cmd = CMD_READ;
      else if (r < 9) cmd = CMD_PING;
      else cmd = 5'($urandom_range(4, 31));
      addr = 8'($urandom_range(0, 19));
      data = $urandom;
      s0 = strobe_count;
      model_apply(cmd, addr, data, resp, wrote);
      issue_packet(cmd, addr, data);
      total++; if (bus.send_data !== 1'b0) begin bad++; $display("[TB] FAIL rnd%0d_n1: got %b want 0", n, bus.send_data); end
      @(negedge clk);
      total++; if (bus.send_data !== 1'b1 || bus.tx_data !== resp) begin bad++; $display("[TB] FAIL rnd%0d_tx: got send=%b tx=%h want 1/%h", n, bus.send_data, bus.tx_data, resp); end
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) begin
        bus.packet_received = 1'($urandom_range(0, 1));
        if (bus.packet_received) model_drop_one();
        @(negedge clk);
        bus.packet_received = 1'b0;
      end
      release_response();
      total++; if (busy !== 1'b0 || strobe_count - s0 !== int'(wrote)) begin bad++; $display("[TB] FAIL rnd%0d_done: got busy=%b strobes=%0d want 0/%0d", n, busy, strobe_count - s0, wrote); end
      total++; if (reg_bank !== model_flat() || drop_count !== 8'(model_drop)) begin bad++; $display("[TB] FAIL rnd%0d_state: got drop=%0d regs=%h want drop=%0d regs=%h", n, drop_count, reg_bank, model_drop, model_flat()); end
    end
  endtask

  task automatic test_hold_off();
    logic [47:0] resp;
    bit wrote;
    bit stable;
    do_reset();
    model_apply(CMD_PING, 8'h21, 32'h1357_9BDF, resp, wrote);
    issue_packet(CMD_PING, 8'h21, 32'h1357_9BDF);
    @(negedge clk);
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus.packet_received = (c == 3 || c == 8 || c == 13);
      @(negedge clk);
      bus.packet_received = 1'b0;
      if (bus.send_data !== 1'b1 || bus.tx_data !== resp || busy !== 1'b1) stable = 1'b0;
    end
    total++; if (!stable) begin bad++; $display("[TB] FAIL hold_stable: got send=%b tx=%h busy=%b want 1/%h/1", bus.send_data, bus.tx_data, busy, resp); end
    total++; if (drop_count !== 8'd3) begin bad++; $display("[TB] FAIL hold_drop3: got %0d want 3", drop_count); end
    bus.packet_received = 1'b1;
    release_response();
    bus.packet_received = 1'b0;
    total++; if (busy !== 1'b0 || bus.send_data !== 1'b0 || drop_count !== 8'd4) begin bad++; $display("[TB] FAIL hold_release: got busy=%b send=%b drop=%0d want 0/0/4", busy, bus.send_data, drop_count); end
    model_drop = 4;
  endtask

  task automatic test_reset_in_send();
    logic [47:0] resp;
    bit wrote;
    do_reset();
    model_apply(CMD_WRITE, 8'h05, 32'hA5A5_5A5A, resp, wrote);
    issue_packet(CMD_WRITE, 8'h05, 32'hA5A5_5A5A);
    @(negedge clk);
    bus.packet_received = 1'b1;
    @(negedge clk);
    bus.packet_received = 1'b0;
    total++; if (drop_count !== 8'd1 || bus.send_data !== 1'b1) begin bad++; $display("[TB] FAIL rsend_pre: got drop=%0d send=%b want 1/1", drop_count, bus.send_data); end
    reset = 1'b1;
    bus.packet_received = 1'b1;
    bus.command = CMD_PING;
    @(negedge clk);
    reset = 1'b0;
    bus.packet_received = 1'b0;
    model_reset();
    total++; if (bus.send_data !== 1'b0 || busy !== 1'b0 || drop_count !== 8'd0 || bus.tx_data !== 48'h0) begin bad++; $display("[TB] FAIL rsend_post: got send=%b busy=%b drop=%0d tx=%h want 0/0/0/0", bus.send_data, busy, drop_count, bus.tx_data); end
    total++; if (reg_bank !== model_flat()) begin bad++; $display("[TB] FAIL rsend_regs: got %h want %h", reg_bank, model_flat()); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rsend_ignored_pkt: got busy=%b want 0", busy); end
  endtask

  task automatic test_saturation();
    logic [47:0] resp;
    bit wrote;
    do_reset();
    model_apply(CMD_READ, 8'h01, 32'h0, resp, wrote);
    issue_packet(CMD_READ, 8'h01, 32'h0);
    @(negedge clk);
    for (int c = 0; c < 300; c++) begin
      bus.packet_received = 1'b1;
      @(negedge clk);
      bus.packet_received = 1'b0;
      @(negedge clk);
    end
    total++; if (drop_count !== 8'd255 || busy !== 1'b1) begin bad++; $display("[TB] FAIL sat_drop: got drop=%0d busy=%b want 255/1", drop_count, busy); end
    release_response();
    total++; if (busy !== 1'b0 || drop_count !== 8'd255) begin bad++; $display("[TB] FAIL sat_release: got busy=%b drop=%0d want 0/255", busy, drop_count); end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_write_read();
    test_errors();
    test_stray_data_sent();
    test_random();
    test_hold_off();
    test_reset_in_send();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
